// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (8 data bits LSB-first, optional parity, 1 stop)
// feeding a show-ahead FIFO of {parity_err, frame_err, data[7:0]} entries.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle, waiting for a 1->0 edge on the synchronized rx
// S_START | timing the start bit; a high vote means a glitch, abort
// S_DATA  | shifting in 8 data bits LSB-first
// S_PARITY| checking the parity bit against the received data
// S_STOP  | voting the stop bit, pushing the entry at mid-bit

module uart_rx_fifo #(
  parameter int CLK_DIV_WIDTH = 8,
  parameter int DEPTH_LOG2    = 4
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div,
  input  logic [1:0]               parity_mode,
  input  logic                     rx,
  input  logic                     rd,
  output logic [9:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [DEPTH_LOG2:0]      count,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic                     busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef logic [CLK_DIV_WIDTH-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic rx_meta_q;
  logic rxs_q;
  logic rxs_prev_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  cnt_t       div_q, div_d;
  logic [1:0] par_q, par_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic       s0_q, s0_d;
  logic       s1_q, s1_d;
  logic       bit_q, bit_d;
  logic       perr_q, perr_d;
  logic       push_q, push_d;
  logic [9:0] entry_q, entry_d;

  cnt_t mid;
  cnt_t mid_m1;
  cnt_t mid_p1;
  cnt_t last;
  logic vote;
  logic cur_vote;
  logic start_det;
  logic par_en;
  logic arm;

  assign mid       = div_q >> 1;
  assign mid_m1    = mid - cnt_t'(1);
  assign mid_p1    = mid + cnt_t'(1);
  assign last      = div_q - cnt_t'(1);
  assign vote      = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  // With clk_div=4 the third sample lands on the last count of the bit, so
  // the vote may not be registered yet when the start bit ends.
  assign cur_vote  = (cnt_q == mid_p1) ? vote : bit_q;
  assign start_det = rxs_prev_q & ~rxs_q;
  assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      par_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      bit_q     <= 1'b1;
      perr_q    <= 1'b0;
      push_q    <= 1'b0;
      entry_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      par_q     <= par_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      bit_q     <= bit_d;
      perr_q    <= perr_d;
      push_q    <= push_d;
      entry_q   <= entry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    par_d     = par_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    bit_d     = bit_q;
    perr_d    = perr_q;
    push_d    = 1'b0;
    entry_d   = entry_q;
    arm       = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = (cnt_q == last) ? '0 : cnt_q + cnt_t'(1);
      if (cnt_q == mid_m1) s0_d = rxs_q;
      if (cnt_q == mid)    s1_d = rxs_q;
      if (cnt_q == mid_p1) bit_d = vote;
    end

    case (state_q)
      S_IDLE: begin
        arm = start_det;
      end
      S_START: begin
        if (cnt_q == last) begin
          if (cur_vote) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == mid_p1) shreg_d = {vote, shreg_q[7:1]};
        if (cnt_q == last) begin
          if (bit_idx_q == 3'd7) state_d = par_en ? S_PARITY : S_STOP;
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        // par_q[1] is set only for odd mode, flipping the expected XOR
        if (cnt_q == mid_p1) perr_d = ^{shreg_q, vote, par_q[1]};
        if (cnt_q == last)   state_d = S_STOP;
      end
      S_STOP: begin
        if (cnt_q == mid_p1) begin
          entry_d = {perr_q, ~vote, shreg_q};
          push_d  = 1'b1;
          state_d = S_IDLE;
          arm     = start_det;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A start edge coinciding with the stop vote (clk_div=4) re-arms directly.
    if (arm) begin
      state_d = S_START;
      cnt_d   = '0;
      div_d   = clk_div;
      par_d   = parity_mode;
      perr_d  = 1'b0;
    end
  end

  logic [9:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  do_pop;
  logic                  do_push;
  logic                  room;

  assign do_pop  = rd && (count_q != '0);
  assign room    = (count_q != DEPTH_CNT) || do_pop;
  assign do_push = push_q && room;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clr_overflow)      ovf_d = 1'b0;
    if (push_q && !room)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= entry_q;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_CNT);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != S_IDLE);
  assign dout     = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table of single frames plus
// hand sequences for overflow, push-with-pop when full, glitches and reset.

module tb_uart_rx_fifo;

  logic       clk;
  logic       resetb;
  logic [7:0] clk_div;
  logic [1:0] parity_mode;
  logic       rx;
  logic       rd;
  logic [9:0] dout;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overflow;
  logic       clr_overflow;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_fifo #(.CLK_DIV_WIDTH(8), .DEPTH_LOG2(2)) dut (
    .clk          (clk),
    .resetb       (resetb),
    .clk_div      (clk_div),
    .parity_mode  (parity_mode),
    .rx           (rx),
    .rd           (rd),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic [1:0] pm;
    logic       pbit;
    logic       sbit;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Call at a posedge-aligned time; each bit lasts exactly div clocks.
  task automatic send_bit(input logic b, input int div);
    #1;
    rx = b;
    repeat (div) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input int div, input logic [1:0] pm,
                            input logic pbit, input logic sbit, input int idle_bits);
    clk_div     = 8'(div);
    parity_mode = pm;
    send_bit(1'b0, div);
    for (int i = 0; i < 8; i++) send_bit(data[i], div);
    if (pm == 2'b01 || pm == 2'b10) send_bit(pbit, div);
    send_bit(sbit, div);
    if (idle_bits > 0) send_bit(1'b1, idle_bits * div);
  endtask

  task automatic wait_nonempty(output int lat);
    lat = 0;
    while (empty && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop_check(input string name, input logic [9:0] exp);
    @(negedge clk);
    check(name, 32'(dout), 32'(exp));
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // Pulses rd or clr_overflow in the cycle right after the receiver leaves
  // STOP, which is the cycle its push is presented to the FIFO.
  task automatic pulse_at_push(input bit use_rd, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!busy) return;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) return;
    if (use_rd) rd = 1'b1;
    else        clr_overflow = 1'b1;
    @(negedge clk);
    rd           = 1'b0;
    clr_overflow = 1'b0;
    ok           = 1'b1;
  endtask

  initial begin
    int lat;
    int nb;
    bit ok;

    vecs[0] = '{8'hA5,  8, 2'b00, 1'b0, 1'b1, 10'h0A5};
    vecs[1] = '{8'h3C, 16, 2'b01, 1'b0, 1'b1, 10'h03C};
    vecs[2] = '{8'h3C, 16, 2'b01, 1'b1, 1'b1, 10'h23C};
    vecs[3] = '{8'h55,  8, 2'b00, 1'b0, 1'b0, 10'h155};
    vecs[4] = '{8'h12,  8, 2'b00, 1'b0, 1'b1, 10'h012};
    vecs[5] = '{8'h07,  8, 2'b10, 1'b0, 1'b1, 10'h007};
    vecs[6] = '{8'h07,  8, 2'b10, 1'b1, 1'b1, 10'h207};
    vecs[7] = '{8'hFF,  4, 2'b11, 1'b0, 1'b1, 10'h0FF};
    vecs[8] = '{8'h00,  5, 2'b01, 1'b1, 1'b1, 10'h200};
    vecs[9] = '{8'h81, 12, 2'b01, 1'b1, 1'b0, 10'h381};

    resetb       = 1'b0;
    rx           = 1'b1;
    rd           = 1'b0;
    clr_overflow = 1'b0;
    clk_div      = 8'd8;
    parity_mode  = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    resetb = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      fork
        send_frame(vecs[i].data, vecs[i].div, vecs[i].pm, vecs[i].pbit, vecs[i].sbit, 2);
        wait_nonempty(lat);
      join
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(!empty), 32'd1);
      if (i == 0) check("vec0_latency_70_90", 32'(lat >= 70 && lat <= 90), 32'd1);
      check($sformatf("vec%0d_count", i), 32'(count), 32'd1);
      pop_check($sformatf("vec%0d_dout", i), vecs[i].exp);
      check($sformatf("vec%0d_empty_after_rd", i), 32'(empty), 32'd1);
    end

    // Single-clock glitch while idle must not start a frame.
    @(posedge clk);
    clk_div = 8'd8;
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    nb = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) nb++;
    end
    repeat (20) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("glitch_busy_1_to_8", 32'(nb >= 1 && nb <= 8), 32'd1);
    check("glitch_busy_idle", 32'(busy), 32'd0);
    check("glitch_no_push", 32'(empty), 32'd1);

    // Fill with back-to-back frames, drop a fifth while clr_overflow collides.
    @(posedge clk);
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 4, 2'b00, 1'b0, 1'b1, (i == 4) ? 2 : 0);
    fork
      send_frame(8'h05, 4, 2'b00, 1'b0, 1'b1, 2);
      pulse_at_push(1'b0, ok);
    join
    @(negedge clk);
    check("ovf_push_seen", 32'(ok), 32'd1);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovf_rd%0d", i), 10'(i));
    @(negedge clk);
    check("ovf_drained", 32'(empty), 32'd1);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("rd_empty_count", 32'(count), 32'd0);
    check("rd_empty_flag", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Push and pop in the same cycle while full.
    @(posedge clk);
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 4, 2'b00, 1'b0, 1'b1, (i == 3) ? 2 : 0);
    @(negedge clk);
    check("pp_full_before", 32'(count), 32'd4);
    @(posedge clk);
    fork
      send_frame(8'h15, 4, 2'b00, 1'b0, 1'b1, 2);
      pulse_at_push(1'b1, ok);
    join
    @(negedge clk);
    check("pp_push_seen", 32'(ok), 32'd1);
    check("pp_count", 32'(count), 32'd4);
    check("pp_no_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("pp_rd%0d", i), 10'h012 + 10'(i));
    @(negedge clk);
    check("pp_drained", 32'(empty), 32'd1);

    // Reset in the middle of a frame with one byte already buffered.
    @(posedge clk);
    send_frame(8'h5A, 8, 2'b00, 1'b0, 1'b1, 2);
    fork
      send_frame(8'h77, 8, 2'b00, 1'b0, 1'b1, 2);
      begin
        repeat (30) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_count", 32'(count), 32'd1);
        resetb = 1'b0;
        #2;
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'd0);
      end
    join
    @(negedge clk);
    resetb = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    fork
      send_frame(8'h3E, 8, 2'b00, 1'b0, 1'b1, 2);
      wait_nonempty(lat);
    join
    @(negedge clk);
    check("post_rst_count", 32'(count), 32'd1);
    pop_check("post_rst_dout", 10'h03E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
